// File: rtl/approx_accum.sv
// approx_accum: streaming signed accumulator with a runtime-selectable
// approximate adder on the low K bits. An exact shadow sum runs alongside
// and the peak |exact - approx| over the burst is tracked. One netlist can
// sweep every mode/K point.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cfg_mode/cfg_k/cfg_len  burst configuration, sampled on start in IDLE
//   start, busy           burst launch / RUN-or-DONE indicator
//   in_valid/in_ready/in_data   sample stream (signed BIT_WIDTH)
//   out_valid/out_ready   result handshake
//   out_acc, out_exact, out_err_max, out_count   burst results
module approx_accum #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int K_MAX     = 5,
  parameter int LEN_WIDTH = 8,
  localparam int KW       = $clog2(K_MAX+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           cfg_mode,
  input  logic [KW-1:0]        cfg_k,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 start,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [ACC_WIDTH-1:0] out_exact,
  output logic [ACC_WIDTH-1:0] out_err_max,
  output logic [LEN_WIDTH-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0]           mode;
    logic [KW-1:0]        k;
    logic [LEN_WIDTH-1:0] len;
  } cfg_t;

  state_t               state;
  cfg_t                 cfg_q;
  logic [ACC_WIDTH-1:0] acc, exact, err_max;
  logic [LEN_WIDTH-1:0] count;

  // ---------------- datapath ----------------
  logic [ACC_WIDTH-1:0] b_ext, lo_mask, p, g, eta, lo_val, hi_sum;
  logic [ACC_WIDTH-1:0] approx_nx, exact_nx, e, err_nx;
  logic [ACC_WIDTH:0]   d, mag;
  logic                 exact_mode, s;
  logic [KW-1:0]        k_eff;

  assign k_eff = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;
  assign b_ext = {{(ACC_WIDTH-BIT_WIDTH){in_data[BIT_WIDTH-1]}}, in_data};
  assign p     = acc ^ b_ext;
  assign g     = acc & b_ext;

  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < ACC_WIDTH; i++) lo_mask[i] = (i < int'(cfg_q.k));
  end

  // ETA1 chain from bit K-1 downward: once a generate is seen, every lower
  // bit is forced to 1.
  always_comb begin
    s   = 1'b0;
    eta = '0;
    for (int i = K_MAX-1; i >= 0; i--) begin
      if (i < int'(cfg_q.k)) begin
        if (i == int'(cfg_q.k) - 1) s = p[i];
        else                        s = s | g[i];
        eta[i] = s | p[i];
      end
    end
  end

  always_comb begin
    case (cfg_q.mode)
      3'd1:    lo_val = acc;
      3'd2:    lo_val = b_ext;
      3'd3:    lo_val = acc | b_ext;
      3'd5:    lo_val = '1;
      3'd6:    lo_val = eta;
      default: lo_val = '0;
    endcase
  end

  // Masking both operands removes any carry out of the low part.
  assign hi_sum     = (acc & ~lo_mask) + (b_ext & ~lo_mask);
  assign exact_mode = (cfg_q.k == '0) || (cfg_q.mode == 3'd0) || (cfg_q.mode == 3'd7);
  assign approx_nx  = exact_mode ? acc + b_ext : hi_sum | (lo_val & lo_mask);
  assign exact_nx   = exact + b_ext;

  assign d      = {exact_nx[ACC_WIDTH-1], exact_nx} - {approx_nx[ACC_WIDTH-1], approx_nx};
  assign mag    = d[ACC_WIDTH] ? -d : d;
  assign e      = mag[ACC_WIDTH] ? '1 : mag[ACC_WIDTH-1:0];
  assign err_nx = (e > err_max) ? e : err_max;

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_q     <= '0;
      acc       <= '0;
      exact     <= '0;
      err_max   <= '0;
      count     <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cfg_q   <= '{mode: cfg_mode, k: k_eff, len: cfg_len};
          acc     <= '0;
          exact   <= '0;
          err_max <= '0;
          count   <= '0;
          busy    <= 1'b1;
          if (cfg_len == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            state    <= RUN;
            in_ready <= 1'b1;
          end
        end
        RUN: if (in_valid) begin
          acc     <= approx_nx;
          exact   <= exact_nx;
          err_max <= err_nx;
          count   <= count + LEN_WIDTH'(1);
          if (count + LEN_WIDTH'(1) == cfg_q.len) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_acc     = acc;
  assign out_exact   = exact;
  assign out_err_max = err_max;
  assign out_count   = count;

endmodule

// File: tb/tb_approx_accum.sv
module tb_approx_accum;
  localparam int BW = 8, AW = 16, KM = 5, LW = 8, KW = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [2:0]    cfg_mode = '0;
  logic [KW-1:0] cfg_k = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          busy, in_ready, out_valid;
  logic [AW-1:0] out_acc, out_exact, out_err_max;
  logic [LW-1:0] out_count;

  approx_accum #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .K_MAX(KM), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_k(cfg_k), .cfg_len(cfg_len),
    .start(start), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_exact(out_exact), .out_err_max(out_err_max),
    .out_count(out_count));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  // model: phase 0 idle, 1 run, 2 done
  int            m_phase = 0, m_mode = 0, m_k = 0;
  logic [AW-1:0] m_acc = '0, m_exact = '0, m_err = '0;
  logic [LW-1:0] m_cnt = '0, m_len = '0;
  logic [BW-1:0] smp [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Approximate sum from the rules: high fields added with no low carry,
  // low field chosen by mode.
  function automatic logic [AW-1:0] m_approx(input int mode, input int k,
                                             input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] hi, r;
    logic bit_v;
    if (k == 0 || mode == 0 || mode == 7) return a + b;
    hi = (a >> k) + (b >> k);
    r  = hi << k;
    for (int i = 0; i < k; i++) begin
      case (mode)
        1: bit_v = a[i];
        2: bit_v = b[i];
        3: bit_v = a[i] | b[i];
        4: bit_v = 1'b0;
        5: bit_v = 1'b1;
        default: begin
          // set if own propagate, top propagate, or any generate between i and K-2
          bit_v = (a[i] ^ b[i]) | (a[k-1] ^ b[k-1]);
          for (int j = i; j <= k-2; j++) bit_v = bit_v | (a[j] & b[j]);
        end
      endcase
      r[i] = bit_v;
    end
    return r;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_mode = 0; m_k = 0;
    m_acc = '0; m_exact = '0; m_err = '0; m_cnt = '0; m_len = '0;
  endtask

  task automatic m_step(input logic [BW-1:0] s);
    logic [AW-1:0] b, na, ne;
    int dd;
    b  = {{(AW-BW){s[BW-1]}}, s};
    na = m_approx(m_mode, m_k, m_acc, b);
    ne = m_exact + b;
    dd = int'($signed(ne)) - int'($signed(na));
    if (dd < 0) dd = -dd;
    if (dd > 65535) dd = 65535;
    if (dd > int'(m_err)) m_err = AW'(dd);
    m_acc = na; m_exact = ne; m_cnt = m_cnt + 1'b1;
    if (m_cnt == m_len) m_phase = 2;
  endtask

  // per-cycle compare against the model
  always @(negedge clk) if (chk_en) begin
    chk("busy", busy, m_phase != 0);
    chk("in_ready", in_ready, m_phase == 1);
    chk("out_valid", out_valid, m_phase == 2);
    chk("out_acc", out_acc, m_acc);
    chk("out_exact", out_exact, m_exact);
    chk("out_err_max", out_err_max, m_err);
    chk("out_count", out_count, m_cnt);
  end

  // all drivers act 1 time unit after the rising edge
  task automatic start_burst(input int mode, input int k, input int len);
    cfg_mode = 3'(mode); cfg_k = KW'(k); cfg_len = LW'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_mode = 3'd5; cfg_k = 3'd1; cfg_len = 8'd9;
    m_mode = mode; m_k = (k > KM) ? KM : k; m_len = LW'(len);
    m_acc = '0; m_exact = '0; m_err = '0; m_cnt = '0;
    m_phase = (len == 0) ? 2 : 1;
  endtask

  task automatic send(input logic [BW-1:0] s, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      in_data = 8'hA5; @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = s; t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      nchk++; nerr++;
      $display("FAIL send_timeout: in_ready stayed 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    m_step(s);
    in_valid = 1'b0;
  endtask

  task automatic finish_burst();
    chk("done_reached", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (m_phase == 2) m_phase = 0;
  endtask

  task automatic run(input int mode, input int k, input int n, input int gap);
    start_burst(mode, k, n);
    for (int i = 0; i < n; i++) send(smp[i], (i == 1) ? gap : 0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", out_acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;

    // exact, negative sample, gap mid-burst
    smp[0] = 8'd5; smp[1] = -8'sd2; smp[2] = 8'd7;
    run(0, 0, 3, 3);
    chk("t1_acc", out_acc, 10); chk("t1_exact", out_exact, 10);
    chk("t1_err", out_err_max, 0); chk("t1_cnt", out_count, 3);
    finish_burst();

    smp[0] = 8'd3; smp[1] = 8'd3;
    run(4, 2, 2, 0);
    chk("trunc0_acc", out_acc, 0); chk("trunc0_exact", out_exact, 6);
    chk("trunc0_err", out_err_max, 6);
    finish_burst();

    smp[0] = 8'd5; smp[1] = 8'd3;
    run(3, 3, 2, 2);
    chk("loa_acc", out_acc, 7); chk("loa_exact", out_exact, 8);
    chk("loa_err", out_err_max, 1);
    finish_burst();

    start_burst(6, 3, 2);
    send(8'd6, 0); chk("eta_step1_acc", out_acc, 7);
    send(8'd3, 0); chk("eta_step2_acc", out_acc, 7);
    chk("eta_exact", out_exact, 9); chk("eta_err", out_err_max, 2);
    finish_burst();

    // cfg_k above K_MAX clamps to 5
    smp[0] = 8'd40; smp[1] = 8'd40;
    run(4, 7, 2, 0);
    chk("clamp_acc", out_acc, 64); chk("clamp_exact", out_exact, 80);
    chk("clamp_err", out_err_max, 16);
    finish_burst();

    smp[0] = -8'sd3; smp[1] = 8'd4;
    run(5, 2, 2, 0);
    chk("trunc1_acc", out_acc, 3); chk("trunc1_exact", out_exact, 1);
    chk("trunc1_err", out_err_max, 2);
    finish_burst();

    // remaining modes checked against the model only
    smp[0] = 8'd20; smp[1] = -8'sd7; smp[2] = 8'd100;
    run(1, 4, 3, 1); finish_burst();
    smp[0] = 8'd9; smp[1] = -8'sd128; smp[2] = 8'd77;
    run(2, 1, 3, 0); finish_burst();
    smp[0] = 8'd7; smp[1] = 8'd1;
    run(7, 3, 2, 0);
    chk("mode7_acc", out_acc, 8); chk("mode7_err", out_err_max, 0);
    finish_burst();
    smp[0] = 8'd127; smp[1] = 8'd127; smp[2] = -8'sd1; smp[3] = 8'd31;
    run(6, 5, 4, 2); finish_burst();

    // len 0 goes straight to DONE with cleared registers; then hold
    start_burst(0, 0, 0);
    chk("len0_valid", out_valid, 1); chk("len0_acc", out_acc, 0);
    chk("len0_exact", out_exact, 0); chk("len0_cnt", out_count, 0);
    start = 1'b1; cfg_mode = 3'd0; cfg_len = 8'd3; in_valid = 1'b1; in_data = 8'd9;
    repeat (5) begin @(posedge clk); #1; end
    chk("hold_in_ready", in_ready, 0); chk("hold_valid", out_valid, 1);
    chk("hold_cnt", out_count, 0);
    start = 1'b0; in_valid = 1'b0;
    finish_burst();

    // reset mid-burst, then a clean burst
    start_burst(0, 0, 4);
    send(8'd9, 0); send(8'd9, 0);
    rst_n = 1'b0; m_reset();
    #1;
    chk("abort_acc", out_acc, 0); chk("abort_exact", out_exact, 0);
    chk("abort_busy", busy, 0); chk("abort_in_ready", in_ready, 0);
    chk("abort_cnt", out_count, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    smp[0] = 8'd1; smp[1] = 8'd1;
    run(0, 0, 2, 0);
    chk("after_abort_acc", out_acc, 2); chk("after_abort_cnt", out_count, 2);
    finish_burst();

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/approx_accum.md
Name: approx_accum

Overview:
- Streaming signed accumulator whose adder is a runtime-selectable approximate adder: exact, copyA, copyB, LOA, trunc0, trunc1 or ETA1.
- The approximation is applied to the low K bits; the split point K is also selectable at runtime.
- An exact shadow accumulator runs alongside and tracks the peak absolute error over each burst.
- Sits between a sample source and the characterisation/metrics logic, so one netlist sweeps every mode/K point without resynthesis.

Parameters:
- BIT_WIDTH, 8, input sample width (signed).
- ACC_WIDTH, 16, accumulator width; must be greater than BIT_WIDTH.
- K_MAX, 5, largest supported approximate split; must be less than ACC_WIDTH.
- LEN_WIDTH, 8, width of the burst-length counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_mode  in  3  0 exact, 1 copyA, 2 copyB, 3 loa, 4 trunc0, 5 trunc1, 6 eta1, 7 exact.
- cfg_k  in  $clog2(K_MAX+1)  requested split K.
- cfg_len  in  LEN_WIDTH  samples per burst.
- start  in  1  begin burst; honoured only in IDLE.
- busy  out  1  high in RUN and DONE.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid and in_ready are both high.
- in_data  in  BIT_WIDTH  signed sample.
- out_valid  out  1  burst result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both high.
- out_acc  out  ACC_WIDTH  approximate sum.
- out_exact  out  ACC_WIDTH  exact sum.
- out_err_max  out  ACC_WIDTH  peak |exact − approx| over the burst.
- out_count  out  LEN_WIDTH  samples accumulated.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy, in_ready, out_valid read 0.
  - All accumulators, the error register, the counter and the latched configuration read 0.
  - Applies at any time, including mid-burst; the partial burst is discarded with no output.
- IDLE, start=1:
  - Latch cfg_mode, cfg_len and K_eff = min(cfg_k, K_MAX).
  - Clear acc, exact, err_max and count.
  - If cfg_len=0, go to DONE; otherwise go to RUN.
  - Configuration inputs are ignored outside this cycle.
- RUN:
  - in_ready=1.
  - On each handshake, with a = acc and b = sign-extended in_data:
    - acc ← approx(a, b);
    - exact ← a_exact + b, wrapping mod 2^ACC_WIDTH;
    - count ← count+1;
    - err_max ← max(err_max, e), where e is computed from the new acc/exact values.
  - When the handshake brings count to len, go to DONE; in_ready drops in the following cycle.
  - Cycles with in_valid=0 leave all state unchanged.
- DONE:
  - out_valid=1 and in_ready=0.
  - Outputs are held stable until out_ready=1.
  - After the result handshake, go to IDLE the next cycle; registers keep their values until the next start.
  - start is ignored while in DONE.
- Latency: results appear on the out_* ports, with out_valid high, in the cycle after the final input handshake.
- approx(a, b), with K = K_eff:
  - If K=0 or mode is 0/7: a + b, mod 2^ACC_WIDTH.
  - Otherwise the high part is out[ACC_WIDTH-1:K] = a[ACC_WIDTH-1:K] + b[ACC_WIDTH-1:K], mod 2^(ACC_WIDTH-K), with no carry in from the low part.
  - Low part out[K-1:0] by mode:
    - copyA = a[K-1:0];
    - copyB = b[K-1:0];
    - loa = a | b;
    - trunc0 = all zeros;
    - trunc1 = all ones;
    - eta1: P = a ^ b, G = a & b; S[K-1] = P[K-1]; S[i] = S[i+1] | G[i]; out[i] = S[i] | P[i].
  - K is a runtime value; implement the low-part masking and the ETA1 chain for every K in 0..K_MAX.
- Error e:
  - d = exact − acc, evaluated in ACC_WIDTH+1 signed bits (both operands sign-extended).
  - e = |d|, saturated to 2^ACC_WIDTH−1.
  - err_max is compared unsigned.
- Overflow: both accumulators wrap silently, with no flag.

Test Plan:
- mode 0, len 3, samples 5, −2, 7 → out_acc 10, out_exact 10, out_err_max 0, out_count 3.
- mode 4 (trunc0), K=2, len 2, samples 3, 3 → out_acc 0, out_exact 6, out_err_max 6.
- mode 3 (loa), K=3, len 2, samples 5, 3 → out_acc 7, out_exact 8, out_err_max 1.
- mode 6 (eta1), K=3, len 2, samples 6, 3 → out_acc 7 after each step, out_exact 9, out_err_max 2.
- Boundaries:
  - cfg_k=7 is clamped to K=5.
  - cfg_len=0 → out_valid the cycle after start with all outputs 0.
  - Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0, start ignored.
  - in_valid gaps mid-burst → sums unchanged.
- Reset during RUN after 2 of 4 samples → all outputs 0 immediately; a following start with mode 0 and samples 1, 1 gives out_acc 2 (no residue from the aborted burst).
